// File: rtl/grant_burst_mux.sv
// Moves one BURST_LEN-beat burst from the granted source onto a registered valid/ready output, then pulses done/abort.
// First accept one cycle after grant, output one cycle after accept; source ready drops while the output is stalled.
module grant_burst_mux #(
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              gnt_0,
   input  logic              gnt_1,
   input  logic [DATA_W-1:0] src0_data,
   input  logic              src0_valid,
   output logic              src0_ready,
   input  logic [DATA_W-1:0] src1_data,
   input  logic              src1_valid,
   output logic              src1_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              done_0,
   output logic              done_1,
   output logic              abort,
   output logic              err_both
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_XFER0   = 2'd1,
      S_XFER1   = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_done_0;
   logic              r_done_1;
   logic              r_abort;
   logic              r_err_both;

   logic              w_slot_free;
   logic              w_rdy0;
   logic              w_rdy1;
   logic              w_acc0;
   logic              w_acc1;
   logic              w_acc;
   logic              w_last;
   logic [DATA_W-1:0] w_acc_data;

   // The output slot can take a new beat when empty or when it drains this same cycle.
   assign w_slot_free = !r_out_valid || out_ready;
   assign w_rdy0      = (r_state == S_XFER0) && gnt_0 && w_slot_free;
   assign w_rdy1      = (r_state == S_XFER1) && gnt_1 && w_slot_free;
   assign w_acc0      = w_rdy0 && src0_valid;
   assign w_acc1      = w_rdy1 && src1_valid;
   assign w_acc       = w_acc0 || w_acc1;
   assign w_last      = (r_cnt == LAST_CNT);
   assign w_acc_data  = w_acc1 ? src1_data : src0_data;

   assign src0_ready  = w_rdy0;
   assign src1_ready  = w_rdy1;
   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign done_0      = r_done_0;
   assign done_1      = r_done_1;
   assign abort       = r_abort;
   assign err_both    = r_err_both;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_done_0    <= 1'b0;
         r_done_1    <= 1'b0;
         r_abort     <= 1'b0;
         r_err_both  <= 1'b0;
      end else begin
         r_done_0 <= 1'b0;
         r_done_1 <= 1'b0;
         r_abort  <= 1'b0;

         if (gnt_0 && gnt_1) begin
            r_err_both <= 1'b1;
         end

         if (w_acc) begin
            r_out_data  <= w_acc_data;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (gnt_0 && !gnt_1) begin
                  r_state <= S_XFER0;
               end else if (gnt_1 && !gnt_0) begin
                  r_state <= S_XFER1;
               end
            end
            S_XFER0: begin
               if (w_acc0) begin
                  if (w_last) begin
                     r_done_0 <= 1'b1;
                     r_cnt    <= '0;
                     r_state  <= S_RELEASE;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end else if (!gnt_0) begin
                  r_abort <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end
            end
            S_XFER1: begin
               if (w_acc1) begin
                  if (w_last) begin
                     r_done_1 <= 1'b1;
                     r_cnt    <= '0;
                     r_state  <= S_RELEASE;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end else if (!gnt_1) begin
                  r_abort <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end
            end
            S_RELEASE: begin
               // Hold off until the requester has dropped its request and the arbiter is idle.
               if (!gnt_0 && !gnt_1) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grant_burst_mux.sv
// Directed bench for grant_burst_mux: bursts, backpressure, abort, double grant, release hold-off, async reset.
module tb_grant_burst_mux;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       gnt_0 = 1'b0;
   logic       gnt_1 = 1'b0;
   logic [7:0] src0_data;
   logic       src0_valid = 1'b0;
   logic       src0_ready;
   logic [7:0] src1_data;
   logic       src1_valid = 1'b0;
   logic       src1_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       done_0;
   logic       done_1;
   logic       abort;
   logic       err_both;

   grant_burst_mux #(.DATA_W(8), .BURST_LEN(4), .CNT_W(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .gnt_0      (gnt_0),
      .gnt_1      (gnt_1),
      .src0_data  (src0_data),
      .src0_valid (src0_valid),
      .src0_ready (src0_ready),
      .src1_data  (src1_data),
      .src1_valid (src1_valid),
      .src1_ready (src1_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .done_0     (done_0),
      .done_1     (done_1),
      .abort      (abort),
      .err_both   (err_both)
   );

   always #5 clock = ~clock;

   int n_vec  = 0;
   int n_miss = 0;

   // Source models: each accepted beat advances that source's data pattern.
   logic [7:0] base0 = 8'h00;
   logic [7:0] base1 = 8'h00;
   logic [7:0] idx0  = 8'h00;
   logic [7:0] idx1  = 8'h00;
   assign src0_data = base0 + idx0;
   assign src1_data = base1 + idx1;

   logic acc0_now = 1'b0;
   logic acc1_now = 1'b0;
   int   cyc      = 0;
   int   n_acc0   = 0;
   int   n_acc1   = 0;
   int   n_done0  = 0;
   int   n_done1  = 0;
   int   n_abort  = 0;
   int   n_viol   = 0;
   int   d0_cyc   = -1;
   logic [7:0] outq[$];
   int         stq[$];

   always @(posedge clock) cyc = cyc + 1;

   // Observe at the falling edge, where every signal is stable for the coming rising edge.
   always @(negedge clock) begin
      acc0_now = src0_valid && src0_ready;
      acc1_now = src1_valid && src1_ready;
      if (acc0_now) n_acc0 = n_acc0 + 1;
      if (acc1_now) n_acc1 = n_acc1 + 1;
      if (out_valid && out_ready) begin
         outq.push_back(out_data);
         stq.push_back(cyc);
      end
      if (done_0) begin
         n_done0 = n_done0 + 1;
         d0_cyc  = cyc;
      end
      if (done_1) n_done1 = n_done1 + 1;
      if (abort) n_abort = n_abort + 1;
      if (out_valid && !out_ready && (src0_ready || src1_ready)) n_viol = n_viol + 1;
   end

   always @(posedge clock) begin
      #1;
      if (acc0_now) idx0 = idx0 + 8'd1;
      if (acc1_now) idx1 = idx1 + 8'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic clr();
      n_acc0  = 0;
      n_acc1  = 0;
      n_done0 = 0;
      n_done1 = 0;
      n_abort = 0;
      n_viol  = 0;
      d0_cyc  = -1;
      idx0    = 8'h00;
      idx1    = 8'h00;
      outq.delete();
      stq.delete();
   endtask

   task automatic check_beats(input string tag, input logic [7:0] b0, input logic [7:0] b1, input int n);
      check({tag, "_nbeats"}, outq.size(), n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] exp;
         exp = (i < 4) ? b0 + 8'(i) : b1 + 8'(i - 4);
         check({tag, "_beat"}, (i < outq.size()) ? {24'h0, outq[i]} : 32'hDEAD, {24'h0, exp});
      end
   endtask

   initial begin
      tick(3);
      // Reset values, reset still asserted
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_done", {done_1, done_0}, 0);
      check("rst_abort", abort, 0);
      check("rst_err_both", err_both, 0);
      check("rst_readys", {src1_ready, src0_ready}, 0);
      reset = 1'b1;
      tick(2);

      // 1: full-throughput burst from source 0
      clr();
      base0 = 8'h11;
      out_ready = 1'b1;
      gnt_0 = 1'b1;
      src0_valid = 1'b1;
      for (int i = 0; i < 60 && n_done0 == 0; i++) tick(1);
      gnt_0 = 1'b0;
      src0_valid = 1'b0;
      tick(4);
      check_beats("t1", 8'h11, 8'h00, 4);
      for (int i = 1; i < 4; i++)
         check("t1_back_to_back", (i < stq.size()) ? stq[i] - stq[0] : -1, i);
      check("t1_done_cycle", d0_cyc, (stq.size() == 4) ? stq[3] : -2);
      check("t1_n_done0", n_done0, 1);
      check("t1_n_acc0", n_acc0, 4);
      check("t1_n_abort", n_abort, 0);

      // 2: source 1 burst with toggling downstream ready
      clr();
      base1 = 8'h21;
      gnt_1 = 1'b1;
      src1_valid = 1'b1;
      for (int i = 0; i < 80 && n_done1 == 0; i++) begin
         out_ready = ~out_ready;
         tick(1);
      end
      gnt_1 = 1'b0;
      src1_valid = 1'b0;
      out_ready = 1'b1;
      tick(4);
      check_beats("t2", 8'h21, 8'h00, 4);
      check("t2_n_acc1", n_acc1, 4);
      check("t2_n_done1", n_done1, 1);
      check("t2_stall_ready", n_viol, 0);
      check("t2_n_done0", n_done0, 0);

      // 3: grant withdrawn after two accepts
      clr();
      base0 = 8'h31;
      gnt_0 = 1'b1;
      src0_valid = 1'b1;
      for (int i = 0; i < 60 && n_acc0 < 2; i++) tick(1);
      gnt_0 = 1'b0;
      tick(4);
      src0_valid = 1'b0;
      check("t3_n_abort", n_abort, 1);
      check("t3_n_done0", n_done0, 0);
      check("t3_n_acc0", n_acc0, 2);
      check_beats("t3", 8'h31, 8'h00, 2);
      check("t3_out_valid", out_valid, 0);

      // 4: double grant from idle
      clr();
      gnt_0 = 1'b1;
      gnt_1 = 1'b1;
      src0_valid = 1'b1;
      src1_valid = 1'b1;
      tick(1);
      check("t4_readys_a", {src1_ready, src0_ready}, 0);
      tick(2);
      check("t4_readys_b", {src1_ready, src0_ready}, 0);
      check("t4_err_set", err_both, 1);
      gnt_0 = 1'b0;
      gnt_1 = 1'b0;
      src0_valid = 1'b0;
      src1_valid = 1'b0;
      tick(3);
      check("t4_err_sticky", err_both, 1);
      check("t4_no_beats", outq.size(), 0);
      check("t4_no_accepts", n_acc0 + n_acc1, 0);

      // 5: grant held after done, then hand-over to source 1
      clr();
      base0 = 8'h41;
      base1 = 8'h51;
      gnt_0 = 1'b1;
      src0_valid = 1'b1;
      src1_valid = 1'b1;
      for (int i = 0; i < 60 && n_done0 == 0; i++) tick(1);
      for (int i = 0; i < 3; i++) begin
         check("t5_release_readys", {src1_ready, src0_ready}, 0);
         tick(1);
      end
      check("t5_acc0_held", n_acc0, 4);
      check("t5_acc1_early", n_acc1, 0);
      gnt_0 = 1'b0;
      tick(1);
      gnt_1 = 1'b1;
      for (int i = 0; i < 60 && n_done1 == 0; i++) tick(1);
      gnt_1 = 1'b0;
      src0_valid = 1'b0;
      src1_valid = 1'b0;
      tick(4);
      check("t5_n_acc1", n_acc1, 4);
      check("t5_dones", {n_done1[7:0], n_done0[7:0]}, 32'h0101);
      check_beats("t5", 8'h41, 8'h51, 8);

      // 6: asynchronous reset in the middle of a burst
      clr();
      base0 = 8'h61;
      gnt_0 = 1'b1;
      src0_valid = 1'b1;
      for (int i = 0; i < 60 && n_acc0 < 2; i++) tick(1);
      check("t6_pre_out_valid", out_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      check("t6_out_valid", out_valid, 0);
      check("t6_out_data", out_data, 0);
      check("t6_readys", {src1_ready, src0_ready}, 0);
      check("t6_pulses", {abort, done_1, done_0}, 0);
      check("t6_err_clear", err_both, 0);
      clr();
      base0 = 8'h71;
      tick(2);
      check("t6_readys_in_reset", {src1_ready, src0_ready}, 0);
      reset = 1'b1;
      for (int i = 0; i < 60 && n_done0 == 0; i++) tick(1);
      gnt_0 = 1'b0;
      src0_valid = 1'b0;
      tick(4);
      check_beats("t6", 8'h71, 8'h00, 4);
      check("t6_n_acc0", n_acc0, 4);
      check("t6_n_done0", n_done0, 1);
      check("t6_n_abort", n_abort, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
